lsu_dmem_master: RTL and testbench
==================================

// Module: lsu_dmem_master
// PURPOSE
//  Load/store initiator between pipeline MEM stage and DMemory byte-addressed data memory.
//  Accepts one load/store per valid/ready handshake and drives DMemory address/data/enable/mask.
//  Captures DMemory's combinational read data and sign/zero-extends it per funct3.
//  Returns the result on a valid/ready response channel; range or funct3 errors become faults.
// PARAMETERS
//  MEM_BYTES      1024  DMemory size in bytes; valid access iff addr+size <= MEM_BYTES
//  ACCESS_CYCLES  1     cycles spent in ACCESS per request (>=1; headroom for slower memory)
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   synchronous, active-high reset
//  req_valid       in   1   request present
//  req_ready       out  1   request accepted when valid&ready
//  req_is_store    in   1   1=store, 0=load
//  req_funct3      in   3   RV32I: LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  req_rd          in   5   destination register tag, returned unchanged
//  resp_valid      out  1   response present
//  resp_ready      in   1   response consumed when valid&ready
//  resp_rdata      out  32  extended load data; 0 for stores and faults
//  resp_rd         out  5   tag of the completing request
//  resp_fault      out  1   1 = rejected; no memory write performed
//  mem_address     out  32  to DMemory address
//  mem_write_data  out  32  to DMemory write_data (unshifted req_wdata)
//  mem_write_enable out 1   to DMemory write_enable
//  mem_write_mask  out  4   to DMemory write_mask
//  mem_read_data   in   32  from DMemory read_data (combinational)
// BEHAVIOUR
//  - States IDLE, ACCESS, RESP. Reset: state=IDLE, req_ready=1, resp_valid=0,
//    resp_rdata/resp_rd/resp_fault=0, mem_address/mem_write_data=0, mem_write_enable=0, mem_write_mask=0.
//  - IDLE: req_ready=1. On req_valid, latch is_store/funct3/addr/wdata/rd.
//    Fault if funct3 illegal for direction (load 011/110/111, store >=011) or {1'b0,addr}+size > MEM_BYTES
//    (33-bit sum, size 1/2/4; no wrap). Fault -> RESP with resp_fault=1. Else -> ACCESS, cnt=ACCESS_CYCLES-1.
//  - ACCESS: req_ready=0; mem_address=latched addr; mem_write_data=latched wdata.
//    Each cycle cnt>0: cnt--. When cnt==0: for stores, mem_write_enable=1 and mask SB=0001 SH=0011 SW=1111
//    for exactly that one cycle; for loads, resp_rdata <= extend(mem_read_data, funct3). Next state -> RESP.
//  - mem_write_enable=0 and mem_write_mask=0 in every other cycle and whenever rst=1.
//    Reset during ACCESS aborts with no write; reset during RESP drops the response.
//  - mem_address holds its last value outside ACCESS.
//  - RESP: resp_valid=1, outputs stable until resp_ready. On resp_ready -> IDLE.
//    A new request is accepted no earlier than the following cycle.
//  - Latency: ACCESS_CYCLES+1 cycles from accept to resp_valid; fault is 1 cycle.
//    Throughput: one request per ACCESS_CYCLES+2 cycles with resp_ready tied high.
//  - Extension: LB sext [7:0]; LBU zext [7:0]; LH sext [15:0]; LHU zext [15:0]; LW passthrough.
//  - Misaligned addresses are legal; DMemory is byte-addressed, so no split or shift is applied.
// STRUCTURE
//  - Shared package lsu_pkg: funct3 localparams (F3_B/H/W/BU/HU), lsu_state_e enum {IDLE, ACCESS, RESP},
//    and function access_size(funct3).
//  - One combinational sub-module load_extender (data_in[31:0], funct3 -> data_out[31:0]).
//  - FSM, counter, request latch and fault check live in lsu_dmem_master.
// TESTING (bench instantiates DMemory behind this block; ACCESS_CYCLES=1 unless noted)
//  - Store and load: SW 0x100 data 0xDEADBEEF.
//    Check exactly one mem_write_enable pulse with mask 1111, then:
//    LW 0x100 -> 0xDEADBEEF; LB 0x100 -> 0xFFFFFFEF; LBU 0x103 -> 0x000000DE; LH 0x102 -> 0xFFFFDEAD.
//  - Partial stores: SB 0x200 data 0x12345678 (mask 0001), then LW 0x200 -> low byte 0x78, upper bytes unchanged.
//    SH 0x201 data 0xABCD -> LHU 0x201 = 0x0000ABCD.
//  - Low-address region: LW 0x4 -> 0x00000010; LW 0x1F -> 0x80000000.
//  - Faults: LW 0x3FE and SH 0x3FF -> resp_fault=1, rdata=0, no write enable.
//    Load funct3=011 -> fault. LB 0x3FF -> ok.
//  - Backpressure: hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0, no extra write pulse;
//    ACCESS_CYCLES=3 -> resp_valid exactly 4 cycles after accept.
//  - Reset: rst during ACCESS of SW 0x100 0x11111111 -> no write.
//    Next LW 0x100 returns old value; all outputs at reset values the cycle after rst.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit data-memory master.
//   - funct3 encodings for RV32I loads and stores
//   - lsu_state_e: IDLE / ACCESS / RESP
//   - lsu_req_t:   request fields still needed after acceptance
//   - helpers: access size, store byte mask, funct3 legality
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_e;

    typedef struct packed {
        logic       is_store;
        logic [2:0] funct3;
    } lsu_req_t;

    // Access size in bytes (1, 2 or 4).
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: access_size = 3'd1;
            F3_H, F3_HU: access_size = 3'd2;
            default:     access_size = 3'd4;
        endcase
    endfunction

    // Byte-enable pattern for a store; data is right-aligned so lanes start at bit 0.
    function automatic logic [3:0] store_mask(input logic [2:0] funct3);
        case (funct3)
            F3_B:    store_mask = 4'b0001;
            F3_H:    store_mask = 4'b0011;
            default: store_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic funct3_illegal(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            funct3_illegal = (funct3 > F3_W);
        end else begin
            funct3_illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
    endfunction

endpackage

// File: rtl/load_extender.sv
// Sign/zero extension of raw load data according to funct3.
//   data_in  [31:0]  raw word from data memory (byte at addr in [7:0])
//   funct3   [2:0]   load type
//   data_out [31:0]  extended result
module load_extender
    import lsu_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [2:0]  funct3,
    output logic [31:0] data_out
);

    always_comb begin
        data_out = data_in;
        case (funct3)
            F3_B:    data_out = {{24{data_in[7]}}, data_in[7:0]};
            F3_H:    data_out = {{16{data_in[15]}}, data_in[15:0]};
            F3_BU:   data_out = {24'h0, data_in[7:0]};
            F3_HU:   data_out = {16'h0, data_in[15:0]};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store initiator between the MEM stage and a byte-addressed data memory.
// One request per valid/ready handshake; the result (or a fault) is returned on a
// valid/ready response channel.
//   clk, rst               clock, synchronous active-high reset
//   req_*                  request channel (valid/ready, store flag, funct3, addr, wdata, rd tag)
//   resp_*                 response channel (valid/ready, extended rdata, rd tag, fault)
//   mem_*                  data memory port (address, write data/enable/mask, read data)
module lsu_dmem_master
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES     = 1024,
    parameter int unsigned ACCESS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_fault,

    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    output logic [3:0]  mem_write_mask,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned CntW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    lsu_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    lsu_req_t      req_q;
    logic [31:0]   mem_address_q, mem_write_data_q;
    logic [31:0]   resp_rdata_q;
    logic [4:0]    resp_rd_q;
    logic          resp_fault_q;

    logic          accept;
    logic          load_done;
    logic          req_fault;
    logic [32:0]   req_end;
    logic [31:0]   ext_data;

    // 33-bit end address so an access near 2^32 cannot wrap into range.
    assign req_end   = {1'b0, req_addr} + {30'h0, access_size(req_funct3)};
    assign req_fault = funct3_illegal(req_is_store, req_funct3) || (req_end > 33'(MEM_BYTES));

    load_extender u_load_extender (
        .data_in  (mem_read_data),
        .funct3   (req_q.funct3),
        .data_out (ext_data)
    );

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_write_enable = 1'b0;
        mem_write_mask   = 4'b0000;
        accept           = 1'b0;
        load_done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = req_fault ? RESP : ACCESS;
                    cnt_d   = CntW'(ACCESS_CYCLES - 1);
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = RESP;
                    // Gated by rst so a reset landing on the write cycle aborts the store.
                    if (req_q.is_store && !rst) begin
                        mem_write_enable = 1'b1;
                        mem_write_mask   = store_mask(req_q.funct3);
                    end
                    load_done = !req_q.is_store;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            req_q            <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            resp_rdata_q     <= '0;
            resp_rd_q        <= '0;
            resp_fault_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_q.is_store <= req_is_store;
                req_q.funct3   <= req_funct3;
                resp_rd_q      <= req_rd;
                resp_fault_q   <= req_fault;
                resp_rdata_q   <= '0;
                // Memory port only moves for accesses that will actually run.
                if (!req_fault) begin
                    mem_address_q    <= req_addr;
                    mem_write_data_q <= req_wdata;
                end
            end
            if (load_done) begin
                resp_rdata_q <= ext_data;
            end
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_rd        = resp_rd_q;
    assign resp_fault     = resp_fault_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
module tb_lsu_dmem_master;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Main DUT (ACCESS_CYCLES = 1) with a byte-addressed memory behind it.
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable;
    logic [3:0]  mem_write_mask;

    lsu_dmem_master #(.MEM_BYTES(1024), .ACCESS_CYCLES(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_is_store     (req_is_store),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_rd           (req_rd),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_rd          (resp_rd),
        .resp_fault       (resp_fault),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_write_mask   (mem_write_mask),
        .mem_read_data    (mem_read_data)
    );

    // Second DUT with a slower access phase; its memory returns a fixed word.
    logic        req_valid3, req_ready3, req_is_store3;
    logic [2:0]  req_funct3_3;
    logic [31:0] req_addr3, req_wdata3;
    logic [4:0]  req_rd3;
    logic        resp_valid3, resp_ready3, resp_fault3;
    logic [31:0] resp_rdata3;
    logic [4:0]  resp_rd3;
    logic [31:0] mem_address3, mem_write_data3;
    logic        mem_write_enable3;
    logic [3:0]  mem_write_mask3;
    logic [31:0] mem_read_data3;
    assign mem_read_data3 = 32'h8000_00F0;

    lsu_dmem_master #(.MEM_BYTES(1024), .ACCESS_CYCLES(3)) dut3 (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid3),
        .req_ready        (req_ready3),
        .req_is_store     (req_is_store3),
        .req_funct3       (req_funct3_3),
        .req_addr         (req_addr3),
        .req_wdata        (req_wdata3),
        .req_rd           (req_rd3),
        .resp_valid       (resp_valid3),
        .resp_ready       (resp_ready3),
        .resp_rdata       (resp_rdata3),
        .resp_rd          (resp_rd3),
        .resp_fault       (resp_fault3),
        .mem_address      (mem_address3),
        .mem_write_data   (mem_write_data3),
        .mem_write_enable (mem_write_enable3),
        .mem_write_mask   (mem_write_mask3),
        .mem_read_data    (mem_read_data3)
    );

    // Initial memory image: zero except a few marker bytes.
    // word@0x004 = 0x00000010, byte 0x022 = 0x80 (so LW 0x1F = 0x80000000),
    // word@0x200 = 0xCAFEF00D, byte 0x3FF = 0x9C.
    function automatic logic [7:0] init_byte(input int a);
        case (a)
            32'h004: init_byte = 8'h10;
            32'h022: init_byte = 8'h80;
            32'h200: init_byte = 8'h0D;
            32'h201: init_byte = 8'hF0;
            32'h202: init_byte = 8'hFE;
            32'h203: init_byte = 8'hCA;
            32'h3FF: init_byte = 8'h9C;
            default: init_byte = 8'h00;
        endcase
    endfunction

    logic [7:0] dmem [0:1023];
    logic       mem_load;
    int         we_count = 0;
    int         we3_count = 0;
    logic [3:0] last_mask = 4'h0;

    always_comb begin
        mem_read_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if ({1'b0, mem_address} + 33'(i) < 33'd1024) begin
                mem_read_data[8*i +: 8] = dmem[10'(mem_address + 32'(i))];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= init_byte(i);
        end else if (mem_write_enable) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_write_mask[i] && ({1'b0, mem_address} + 33'(i) < 33'd1024)) begin
                    dmem[10'(mem_address + 32'(i))] <= mem_write_data[8*i +: 8];
                end
            end
        end
    end

    always @(posedge clk) begin
        if (mem_write_enable) begin
            we_count  <= we_count + 1;
            last_mask <= mem_write_mask;
        end
        if (mem_write_enable3) we3_count <= we3_count + 1;
    end

    // Reference model: flat byte array updated from transaction semantics.
    logic [7:0] ref_mem [0:1023];

    task automatic ref_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic fault);
        int     size;
        logic   legal;
        longint end_a;
        longint val;
        size  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end_a = longint'({32'h0, addr}) + longint'(size);
        fault = !legal || (end_a > 1024);
        rdata = 32'h0;
        if (!fault) begin
            if (st) begin
                for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < size; i++) val += longint'(ref_mem[int'(addr) + i]) << (8 * i);
                if (f3 == 3'd0 && val >= 128)   val -= 256;
                if (f3 == 3'd1 && val >= 32768) val -= 65536;
                rdata = 32'(val);
            end
        end
    endtask

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Runs one transaction on the main DUT, holding resp_ready low for 'hold' cycles.
    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input int hold,
                          output logic [31:0] rdata, output logic fault, output logic [4:0] rd_o,
                          output int lat, output int pulses, output logic stable);
        int we0;
        int k;
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        we0          = we_count;
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
        end while (!resp_valid && lat < 20);
        rdata  = resp_rdata;
        fault  = resp_fault;
        rd_o   = resp_rd;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!resp_valid || req_ready || resp_rdata !== rdata || resp_fault !== fault ||
                resp_rd !== rd_o) stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        pulses = we_count - we0;
    endtask

    task automatic txn3(input logic st, input logic [2:0] f3, input logic [31:0] exp_rdata);
        int lat;
        int w0;
        @(negedge clk);
        w0            = we3_count;
        req_valid3    = 1'b1;
        req_is_store3 = st;
        req_funct3_3  = f3;
        req_addr3     = 32'h40;
        req_wdata3    = 32'h1234_5678;
        req_rd3       = 5'd9;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            req_valid3 = 1'b0;
            lat++;
        end while (!resp_valid3 && lat < 20);
        check("ac3_latency", lat, 4);
        check("ac3_rdata", resp_rdata3, exp_rdata);
        check("ac3_rd", resp_rd3, 5'd9);
        resp_ready3 = 1'b1;
        @(negedge clk);
        resp_ready3 = 1'b0;
        check("ac3_write_pulses", we3_count - w0, st ? 1 : 0);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        logic [3:0]  exp_mask;
        int          hold;
    } vec_t;

    localparam int NVec = 19;
    vec_t vecs [NVec];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] rdata, exp_rdata;
        logic        fault, exp_fault, stable;
        logic [4:0]  rd_o, rd;
        int          lat, pulses, we_before;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        logic [2:0]  load_f3 [5];

        load_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        //            st    f3      addr          wdata          rdata          flt   mask  hold
        vecs[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 4'hF, 0};
        vecs[1]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'h0, 5};
        vecs[2]  = '{1'b0, 3'b000, 32'h0000_0100, 32'h0,         32'hFFFF_FFEF, 1'b0, 4'h0, 0};
        vecs[3]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h0000_00DE, 1'b0, 4'h0, 0};
        vecs[4]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'hFFFF_DEAD, 1'b0, 4'h0, 0};
        vecs[5]  = '{1'b1, 3'b000, 32'h0000_0200, 32'h1234_5678, 32'h0000_0000, 1'b0, 4'h1, 0};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_0200, 32'h0,         32'hCAFE_F078, 1'b0, 4'h0, 0};
        vecs[7]  = '{1'b1, 3'b001, 32'h0000_0201, 32'h0000_ABCD, 32'h0000_0000, 1'b0, 4'h3, 5};
        vecs[8]  = '{1'b0, 3'b101, 32'h0000_0201, 32'h0,         32'h0000_ABCD, 1'b0, 4'h0, 0};
        vecs[9]  = '{1'b0, 3'b010, 32'h0000_0004, 32'h0,         32'h0000_0010, 1'b0, 4'h0, 0};
        vecs[10] = '{1'b0, 3'b010, 32'h0000_001F, 32'h0,         32'h8000_0000, 1'b0, 4'h0, 0};
        vecs[11] = '{1'b0, 3'b010, 32'h0000_03FE, 32'h0,         32'h0000_0000, 1'b1, 4'h0, 0};
        vecs[12] = '{1'b1, 3'b001, 32'h0000_03FF, 32'h0000_7777, 32'h0000_0000, 1'b1, 4'h0, 0};
        vecs[13] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b1, 4'h0, 3};
        vecs[14] = '{1'b0, 3'b000, 32'h0000_03FF, 32'h0,         32'hFFFF_FF9C, 1'b0, 4'h0, 0};
        vecs[15] = '{1'b1, 3'b010, 32'h0000_03FC, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0, 4'hF, 0};
        vecs[16] = '{1'b1, 3'b011, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'h0, 0};
        vecs[17] = '{1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0,         32'h0000_0000, 1'b1, 4'h0, 0};
        vecs[18] = '{1'b0, 3'b010, 32'h0000_03FC, 32'h0,         32'h5A5A_5A5A, 1'b0, 4'h0, 0};

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);

        rst          = 1'b1;
        mem_load     = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'd0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_rd       = 5'd0;
        resp_ready   = 1'b0;
        req_valid3    = 1'b0;
        req_is_store3 = 1'b0;
        req_funct3_3  = 3'd0;
        req_addr3     = 32'h0;
        req_wdata3    = 32'h0;
        req_rd3       = 5'd0;
        resp_ready3   = 1'b0;
        repeat (3) @(posedge clk);
        mem_load = 1'b0;
        @(negedge clk);

        check("reset_req_ready", req_ready, 1'b1);
        check("reset_resp_valid", resp_valid, 1'b0);
        check("reset_resp_rdata", resp_rdata, 32'h0);
        check("reset_resp_fault", resp_fault, 1'b0);
        check("reset_mem_address", mem_address, 32'h0);
        check("reset_mem_we_mask", {mem_write_enable, mem_write_mask}, 5'h0);
        rst = 1'b0;

        // Directed table.
        for (int v = 0; v < NVec; v++) begin
            rd = 5'(v + 1);
            do_txn(vecs[v].st, vecs[v].f3, vecs[v].addr, vecs[v].wdata, rd, vecs[v].hold,
                   rdata, fault, rd_o, lat, pulses, stable);
            ref_txn(vecs[v].st, vecs[v].f3, vecs[v].addr, vecs[v].wdata, exp_rdata, exp_fault);
            check($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_rdata);
            check($sformatf("vec%0d_fault", v), fault, vecs[v].exp_fault);
            check($sformatf("vec%0d_rd", v), rd_o, rd);
            check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_fault ? 1 : 2);
            check($sformatf("vec%0d_write_pulses", v), pulses,
                  (vecs[v].st && !vecs[v].exp_fault) ? 1 : 0);
            if (vecs[v].st && !vecs[v].exp_fault) check($sformatf("vec%0d_mask", v), last_mask,
                                                        vecs[v].exp_mask);
            if (vecs[v].hold > 0) check($sformatf("vec%0d_backpressure_stable", v), stable, 1'b1);
        end

        // Reset in the middle of a store's access phase: no write, outputs reset.
        @(negedge clk);
        we_before    = we_count;
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        req_funct3   = 3'b010;
        req_addr     = 32'h100;
        req_wdata    = 32'h1111_1111;
        req_rd       = 5'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check("rst_write_enable_gated", mem_write_enable, 1'b0);
        @(negedge clk);
        check("rst_no_write", we_count - we_before, 0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_rd", resp_rd, 5'd0);
        check("rst_resp_fault", resp_fault, 1'b0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_write_data", mem_write_data, 32'h0);
        check("rst_mem_mask", mem_write_mask, 4'h0);
        rst = 1'b0;
        do_txn(1'b0, 3'b010, 32'h100, 32'h0, 5'd4, 0, rdata, fault, rd_o, lat, pulses, stable);
        check("post_rst_lw_old_value", rdata, 32'hDEAD_BEEF);

        // Slower access phase.
        txn3(1'b0, 3'b000, 32'hFFFF_FFF0);
        txn3(1'b1, 3'b010, 32'h0000_0000);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 120; n++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (st) f3 = 3'($urandom_range(0, 2));
            else f3 = load_f3[$urandom_range(0, 4)];
            case ($urandom_range(0, 9))
                0:       addr = $urandom;
                1:       addr = 32'(1020 + $urandom_range(0, 3));
                default: addr = 32'($urandom_range(32'h300, 32'h3FF));
            endcase
            wdata = $urandom;
            rd    = 5'($urandom);
            do_txn(st, f3, addr, wdata, rd, $urandom_range(0, 2), rdata, fault, rd_o, lat,
                   pulses, stable);
            ref_txn(st, f3, addr, wdata, exp_rdata, exp_fault);
            check($sformatf("rnd%0d_rdata", n), rdata, exp_rdata);
            check($sformatf("rnd%0d_fault", n), fault, exp_fault);
            check($sformatf("rnd%0d_rd", n), rd_o, rd);
            check($sformatf("rnd%0d_write_pulses", n), pulses, (st && !exp_fault) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
